// File: rtl/dircc_node_mem_arbiter.sv
// Purpose: round-robin share of one DiRCC node memory port among NUM_REQ requesters, one transaction at a time.
// Latency: write acks 2 cycles after the IDLE sampling cycle, read acks 2+READ_LATENCY cycles after it.
// Backpressure: a requester holds req and its fields until its single-cycle ack; losers simply wait.
module dircc_node_mem_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         resp_readdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_address,
    output logic                      mem_write,
    output logic [DATA_W-1:0]         mem_writedata,
    input  logic [DATA_W-1:0]         mem_readdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last;
    logic               lat_write;
    logic [CNT_W-1:0]   cnt;

    // Arbitration result for the current cycle; only consumed in IDLE.
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // Scan requesters starting just after the previous winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last) + k) % NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    // Mux out the winner's fields from the flat request vectors.
    always_comb begin
        win_onehot = '0;
        sel_write  = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == win_idx) begin
                win_onehot[i] = 1'b1;
                sel_write     = req_write[i];
                sel_addr      = req_address[i*ADDR_W +: ADDR_W];
                sel_wdata     = req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state         <= IDLE;
            last          <= IDX_W'(NUM_REQ - 1);
            lat_write     <= 1'b0;
            cnt           <= '0;
            ack           <= '0;
            grant         <= '0;
            busy          <= 1'b0;
            resp_readdata <= '0;
            mem_address   <= '0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
        end else begin
            // ack and the write strobe are single-cycle pulses by construction.
            ack       <= '0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        // The memory port registers double as the request latch,
                        // so the address is on the port in the ISSUE cycle.
                        lat_write     <= sel_write;
                        mem_address   <= sel_addr;
                        mem_writedata <= sel_wdata;
                        mem_write     <= sel_write;
                        grant         <= win_onehot;
                        last          <= win_idx;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lat_write) begin
                        ack   <= grant;
                        state <= RESP;
                    end else begin
                        cnt   <= CNT_W'(READ_LATENCY);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        resp_readdata <= mem_readdata;
                        ack           <= grant;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dircc_node_mem_arbiter.sv
// Purpose: directed bench for dircc_node_mem_arbiter with READ_LATENCY 1 and 3 instances.
// Latency: inputs driven and outputs sampled on the falling edge, one step per cycle.
// Backpressure: requesters hold req until ack unless a step drops it on purpose.
module tb_dircc_node_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 15;
    localparam int DW = 16;

    logic            clk_clk = 1'b0;
    logic            reset_reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_address = '0;
    logic [N*DW-1:0] req_writedata = '0;

    logic [N-1:0]  ack,  ack3;
    logic [DW-1:0] resp, resp3;
    logic [N-1:0]  grant, grant3;
    logic          busy, busy3;
    logic [AW-1:0] maddr, maddr3;
    logic          mwr, mwr3;
    logic [DW-1:0] mwd, mwd3;
    logic [DW-1:0] mrd, mrd3;

    logic [DW-1:0] rd1;
    logic [DW-1:0] p3 [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_clk = ~clk_clk;

    dircc_node_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .req(req), .req_write(req_write), .req_address(req_address), .req_writedata(req_writedata),
        .ack(ack), .resp_readdata(resp), .grant(grant), .busy(busy),
        .mem_address(maddr), .mem_write(mwr), .mem_writedata(mwd), .mem_readdata(mrd)
    );

    dircc_node_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) dut3 (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .req(req), .req_write(req_write), .req_address(req_address), .req_writedata(req_writedata),
        .ack(ack3), .resp_readdata(resp3), .grant(grant3), .busy(busy3),
        .mem_address(maddr3), .mem_write(mwr3), .mem_writedata(mwd3), .mem_readdata(mrd3)
    );

    // Memory contents: 0x0042 holds 0xA5A5, every other word is addr ^ 0x3C00.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 15'h0042) return 16'hA5A5;
        return {1'b0, a} ^ 16'h3C00;
    endfunction

    // Read pipelines: data valid READ_LATENCY cycles after the address appears.
    always_ff @(posedge clk_clk) begin
        rd1   <= mem_fn(maddr);
        p3[0] <= mem_fn(maddr3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mrd  = rd1;
    assign mrd3 = p3[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req[i]                      = 1'b1;
        req_write[i]                = wr;
        req_address[i*AW +: AW]     = a;
        req_writedata[i*DW +: DW]   = wd;
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        req         = '0;
        req_write   = '0;
        repeat (2) @(negedge clk_clk);
        reset_reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] exp_oh;
        int           order [3];

        // ---- reset state ----
        repeat (2) @(negedge clk_clk);
        check("rst_ack",   32'(ack),   32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_mwr",   32'(mwr),   32'h0);
        check("rst_maddr", 32'(maddr), 32'h0);
        check("rst_mwd",   32'(mwd),   32'h0);
        check("rst_resp",  32'(resp),  32'h0);
        reset_reset = 1'b0;

        // ---- single write by requester 0 ----
        do_reset();
        set_req(0, 1'b1, 15'h1234, 16'hBEEF);                    // cycle 0
        @(negedge clk_clk);                                       // cycle 1
        check("wr_mwr_c1",   32'(mwr),   32'h1);
        check("wr_maddr_c1", 32'(maddr), 32'h1234);
        check("wr_mwd_c1",   32'(mwd),   32'hBEEF);
        check("wr_grant_c1", 32'(grant), 32'h1);
        check("wr_ack_c1",   32'(ack),   32'h0);
        @(negedge clk_clk);                                       // cycle 2
        check("wr_ack_c2",   32'(ack),   32'h1);
        check("wr_mwr_c2",   32'(mwr),   32'h0);
        req = '0;
        @(negedge clk_clk);                                       // cycle 3
        check("wr_busy_c3",  32'(busy),  32'h0);
        check("wr_ack_c3",   32'(ack),   32'h0);
        check("wr_grant_c3", 32'(grant), 32'h0);

        // ---- single read by requester 2, latency 1 and 3 ----
        do_reset();
        set_req(2, 1'b0, 15'h0042, 16'h0000);                    // cycle 0
        @(negedge clk_clk);                                       // cycle 1
        check("rd_mwr_c1",   32'(mwr),   32'h0);
        check("rd_maddr_c1", 32'(maddr), 32'h0042);
        @(negedge clk_clk);                                       // cycle 2
        check("rd_mwr_c2",   32'(mwr),   32'h0);
        check("rd_ack_c2",   32'(ack),   32'h0);
        @(negedge clk_clk);                                       // cycle 3
        check("rd_mwr_c3",   32'(mwr),   32'h0);
        check("rd_ack_c3",   32'(ack),   32'h4);
        check("rd_resp_c3",  32'(resp),  32'hA5A5);
        check("rd3_ack_c3",  32'(ack3),  32'h0);
        req = '0;
        @(negedge clk_clk);                                       // cycle 4
        check("rd_busy_c4",  32'(busy),  32'h0);
        check("rd3_ack_c4",  32'(ack3),  32'h0);
        check("rd3_mwr_c4",  32'(mwr3),  32'h0);
        @(negedge clk_clk);                                       // cycle 5
        check("rd3_ack_c5",  32'(ack3),  32'h4);
        check("rd3_resp_c5", 32'(resp3), 32'hA5A5);
        check("rd_ack_c5",   32'(ack),   32'h0);

        // ---- fairness: all four reading continuously ----
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(15'h0100 + i), 16'h0000);
        for (int t = 0; t < 8; t++) begin
            exp_oh = 4'(1 << (t % 4));
            check("fair_ack_c0", 32'(ack), 32'h0);
            @(negedge clk_clk);
            check("fair_grant", 32'(grant), 32'(exp_oh));
            @(negedge clk_clk);
            check("fair_ack_c2", 32'(ack), 32'h0);
            @(negedge clk_clk);
            check("fair_ack", 32'(ack), 32'(exp_oh));
            check("fair_resp", 32'(resp), 32'(16'h3D00 | 16'(t % 4)));
            @(negedge clk_clk);
        end
        req = '0;

        // ---- wrap-around priority after last = 2 ----
        do_reset();
        set_req(2, 1'b1, 15'h0002, 16'h0000);
        @(negedge clk_clk);
        check("wrap_pre_grant", 32'(grant), 32'h4);
        @(negedge clk_clk);
        check("wrap_pre_ack", 32'(ack), 32'h4);
        req = '0;
        set_req(0, 1'b1, 15'h0010, 16'h1000);
        set_req(1, 1'b1, 15'h0011, 16'h1001);
        set_req(3, 1'b1, 15'h0013, 16'h1003);
        @(negedge clk_clk);                                       // IDLE sampling 4'b1011
        order[0] = 3; order[1] = 0; order[2] = 1;
        for (int k = 0; k < 3; k++) begin
            exp_oh = 4'(1 << order[k]);
            @(negedge clk_clk);
            check("wrap_grant", 32'(grant), 32'(exp_oh));
            check("wrap_maddr", 32'(maddr), 32'h0010 + 32'(order[k]));
            check("wrap_mwr",   32'(mwr),   32'h1);
            @(negedge clk_clk);
            check("wrap_ack",   32'(ack),   32'(exp_oh));
            check("wrap_mwr_ack", 32'(mwr), 32'h0);
            @(negedge clk_clk);
        end
        req = '0;

        // ---- requester 1 drops req during its write ----
        do_reset();
        set_req(1, 1'b1, 15'h2222, 16'h1357);                    // cycle 0
        @(negedge clk_clk);                                       // cycle 1
        check("drop_mwr_c1",   32'(mwr),   32'h1);
        check("drop_maddr_c1", 32'(maddr), 32'h2222);
        check("drop_mwd_c1",   32'(mwd),   32'h1357);
        req = '0;
        @(negedge clk_clk);                                       // cycle 2
        check("drop_ack_c2",   32'(ack),   32'h2);
        @(negedge clk_clk);                                       // cycle 3
        check("drop_busy_c3",  32'(busy),  32'h0);

        // ---- reset in the middle of a read ----
        do_reset();
        set_req(3, 1'b0, 15'h0333, 16'h0000);                    // cycle 0
        repeat (3) @(negedge clk_clk);                            // cycle 3
        check("rr_first_ack",  32'(ack),  32'h8);
        check("rr_first_resp", 32'(resp), 32'h3F33);
        req = '0;
        @(negedge clk_clk);                                       // IDLE, new cycle 0
        set_req(0, 1'b0, 15'h0042, 16'h0000);
        @(negedge clk_clk);                                       // ISSUE
        check("rr_grant_issue", 32'(grant), 32'h1);
        @(negedge clk_clk);                                       // WAIT
        check("rr_resp_held",   32'(resp),  32'h3F33);
        reset_reset = 1'b1;
        @(negedge clk_clk);                                       // after reset edge
        check("rr_ack",   32'(ack),   32'h0);
        check("rr_grant", 32'(grant), 32'h0);
        check("rr_busy",  32'(busy),  32'h0);
        check("rr_mwr",   32'(mwr),   32'h0);
        check("rr_resp",  32'(resp),  32'h0);
        reset_reset = 1'b0;
        req = '0;
        set_req(3, 1'b0, 15'h0055, 16'h0000);                    // cycle 0
        @(negedge clk_clk);                                       // cycle 1
        check("rr_re_grant", 32'(grant), 32'h8);
        check("rr_re_ack1",  32'(ack),   32'h0);
        @(negedge clk_clk);                                       // cycle 2
        check("rr_re_ack2",  32'(ack),   32'h0);
        @(negedge clk_clk);                                       // cycle 3
        check("rr_re_ack",   32'(ack),   32'h8);
        check("rr_re_resp",  32'(resp),  32'h3C55);
        req = '0;
        @(negedge clk_clk);
        check("rr_re_idle",  32'(busy),  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dircc_node_mem_arbiter.md
Name: dircc_node_mem_arbiter

Overview:
Round-robin arbiter that shares one DiRCC node memory port among NUM_REQ requesters, e.g. the node core, the host loader and the debug/readback path. The node memory port has a 15-bit word address, 16-bit read and write data, and a write strobe only. Reads are implicit: data returns READ_LATENCY cycles after the address is presented. The arbiter sits between the requesters and one node_<id>_mem port of the system and runs one transaction at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 15, memory word address width
DATA_W, 16, memory data width
READ_LATENCY, 1, cycles from address presented to mem_readdata valid (1..4)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request; held with its fields stable until that requester's ack
req_write  in  NUM_REQ  1 = write, 0 = read
req_address  in  NUM_REQ*ADDR_W  flat vector; slice i belongs to requester i
req_writedata  in  NUM_REQ*DATA_W  flat vector; slice i belongs to requester i
ack  out  NUM_REQ  one-hot single-cycle completion pulse
resp_readdata  out  DATA_W  read data; valid in the ack cycle, held until the next read completes
grant  out  NUM_REQ  one-hot owner of the in-flight transaction; 0 when idle
busy  out  1  high when the state is not IDLE
mem_address  out  ADDR_W  to node mem port
mem_write  out  1  to node mem port
mem_writedata  out  DATA_W  to node mem port
mem_readdata  in  DATA_W  from node mem port

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is reset_reset, synchronous and active-high.
- Reset values: all outputs 0. State = IDLE. Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
- States: IDLE, ISSUE, WAIT, RESP.
- All outputs are registered.
- IDLE, any req high:
  - The winner is the first set bit scanning from (last+1) mod NUM_REQ upward, with wrap-around.
  - Latch the winner's write flag, address and writedata.
  - Set grant, set last = winner, go to ISSUE.
- IDLE, no req: stay in IDLE. mem_write = 0. mem_address and mem_writedata hold their last values.
- ISSUE (1 cycle):
  - Drive mem_address and mem_writedata from the latch.
  - mem_write = 1 only for a write, and only in this cycle.
  - Write → RESP. Read → WAIT with counter = READ_LATENCY.
- WAIT:
  - mem_address is held and mem_write = 0.
  - Decrement the counter each cycle.
  - In the final WAIT cycle (the READ_LATENCY-th), capture mem_readdata into resp_readdata, then go to RESP.
- RESP (1 cycle):
  - ack[winner] = 1.
  - Clear grant in the next cycle and go to IDLE.
- Latency, counting the IDLE sampling cycle as 0:
  - Write: mem_write in cycle 1, ack in cycle 2, next arbitration in cycle 3.
  - Read: address from cycle 1, capture in cycle 1+READ_LATENCY, ack in cycle 2+READ_LATENCY.
- Handshake:
  - A requester may drop req or present a new request in the cycle after ack; it is sampled in the IDLE cycle that follows.
  - req still high in the IDLE cycle after ack counts as a new request.
- req dropped mid-transaction: the latched transaction still completes and ack still pulses.
- Field changes after the IDLE latch cycle are ignored.
- Simultaneous requests: exactly one winner. The pointer rotates, so with all NUM_REQ requesting continuously each is served once per NUM_REQ transactions.
- A lone requester is served back-to-back with no starvation penalty.
- Reset asserted in any state:
  - Next cycle is IDLE and all outputs are 0, including mem_write.
  - The aborted transaction gets no ack.
  - A write aborted during its ISSUE cycle has already been presented to memory.
- At most one bit of ack and of grant is ever set. ack and mem_write are never high in the same cycle.

Test Plan:
- Single write: reset, then req[0]=1, write=1, addr=0x1234, wdata=0xBEEF. Required: mem_write=1 with mem_address=0x1234 and mem_writedata=0xBEEF in cycle 1; ack=4'b0001 in cycle 2; busy low in cycle 3.
- Single read, READ_LATENCY=1: the memory model returns 0xA5A5 for address 0x0042. req[2] reads 0x0042. Required: mem_write never high; ack=4'b0100 in cycle 3 with resp_readdata=0xA5A5. Repeat with READ_LATENCY=3: ack in cycle 5.
- Fairness: all four requesters hold continuous reads after reset. Required: ack order 0,1,2,3,0,1,2,3 over 8 transactions, each ack one cycle wide.
- Wrap-around priority: last=2, then req=4'b1011. Required: grant 3 first, then 0, then 1.
- Dropped request: req[1] issues a write, then deasserts in cycle 1. Required: mem_write in cycle 1 and ack[1] in cycle 2 regardless.
- Reset mid-read: reset_reset pulses during WAIT. Required: no ack; next cycle has grant=0, busy=0, mem_write=0 and resp_readdata=0; a subsequent req[3] read completes normally.
